spell_mem_arbiter: RTL

- Two-port arbiter and sequencer in front of the shared single-port spell memory (code + data spaces, select/data_ready handshake).
- Port A serves the core: instruction fetch plus load/store. Port B serves the host/debug loader.
- Arbitrates between the ports round-robin, holds the memory request stable until data_ready, returns read data, then forces the one-cycle select-low gap the memory needs to re-arm.
- A per-access timeout guards against a memory that never responds.

---
 rtl/spell_mem_arbiter_if.sv | 53 +++++
 rtl/spell_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spell_mem_arbiter_if.sv
// Bundle of every handshake and bus signal around the spell memory arbiter:
// the two requester ports (A = core, B = host/debug loader), the error
// pulse, and the single-port memory side.
interface spell_mem_arbiter_if;
    // Port A (core: fetch and load/store)
    logic       a_req;
    logic [7:0] a_addr;
    logic [1:0] a_type;
    logic       a_write;
    logic [7:0] a_wdata;
    logic       a_done;
    logic [7:0] a_rdata;
    // Port B (host/debug loader)
    logic       b_req;
    logic [7:0] b_addr;
    logic [1:0] b_type;
    logic       b_write;
    logic [7:0] b_wdata;
    logic       b_done;
    logic [7:0] b_rdata;
    // Timeout indication, coincident with the owner's done
    logic       err;
    // Shared memory side
    logic       mem_select;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [1:0] mem_type;
    logic       mem_write;
    logic [7:0] mem_data_out;
    logic       mem_data_ready;

    // Arbiter view
    modport slave (
        input  a_req, a_addr, a_type, a_write, a_wdata,
        output a_done, a_rdata,
        input  b_req, b_addr, b_type, b_write, b_wdata,
        output b_done, b_rdata,
        output err,
        output mem_select, mem_addr, mem_data_in, mem_type, mem_write,
        input  mem_data_out, mem_data_ready
    );

    // Environment view: requesters plus the memory itself
    modport master (
        output a_req, a_addr, a_type, a_write, a_wdata,
        input  a_done, a_rdata,
        output b_req, b_addr, b_type, b_write, b_wdata,
        input  b_done, b_rdata,
        input  err,
        input  mem_select, mem_addr, mem_data_in, mem_type, mem_write,
        output mem_data_out, mem_data_ready
    );
endinterface

// File: rtl/spell_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared single-port
// spell memory. A granted request is held on the memory until data_ready
// (or until the access timer expires), the owner gets a one-cycle done
// pulse, and a one-cycle select-low RELEASE state lets the memory re-arm.
// TIMEOUT legal range is 1..255 (8-bit access timer).
module spell_mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    spell_mem_arbiter_if.slave   bus
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic       OWNER_A    = 1'b0;
    localparam logic       OWNER_B    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_last_owner;
    logic [7:0] r_timer;

    logic       r_a_done;
    logic [7:0] r_a_rdata;
    logic       r_b_done;
    logic [7:0] r_b_rdata;
    logic       r_err;

    logic       r_mem_select;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_data_in;
    logic [1:0] r_mem_type;
    logic       r_mem_write;

    logic       w_req_any;
    logic       w_grant_b;
    logic [7:0] w_sel_addr;
    logic [1:0] w_sel_type;
    logic       w_sel_write;
    logic [7:0] w_sel_wdata;
    logic       w_timeout;

    assign w_req_any = bus.a_req | bus.b_req;
    assign w_timeout = (r_timer == TIMER_LAST);

    // Round-robin choice: a lone requester wins, a tie goes to the port that did not own the memory last
    always_comb begin
        w_grant_b = 1'b0;
        if (bus.a_req && bus.b_req) begin
            w_grant_b = (r_last_owner == OWNER_A);
        end else if (bus.b_req) begin
            w_grant_b = 1'b1;
        end else begin
            w_grant_b = 1'b0;
        end
    end

    // Request fields of the port that would be granted this cycle
    always_comb begin
        w_sel_addr  = 8'h00;
        w_sel_type  = 2'b00;
        w_sel_write = 1'b0;
        w_sel_wdata = 8'h00;
        if (w_grant_b) begin
            w_sel_addr  = bus.b_addr;
            w_sel_type  = bus.b_type;
            w_sel_write = bus.b_write;
            w_sel_wdata = bus.b_wdata;
        end else begin
            w_sel_addr  = bus.a_addr;
            w_sel_type  = bus.a_type;
            w_sel_write = bus.a_write;
            w_sel_wdata = bus.a_wdata;
        end
    end

    // Arbitration/sequencing FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWNER_A;
            r_last_owner  <= OWNER_B;
            r_timer       <= 8'h00;
            r_a_done      <= 1'b0;
            r_a_rdata     <= 8'h00;
            r_b_done      <= 1'b0;
            r_b_rdata     <= 8'h00;
            r_err         <= 1'b0;
            r_mem_select  <= 1'b0;
            r_mem_addr    <= 8'h00;
            r_mem_data_in <= 8'h00;
            r_mem_type    <= 2'b00;
            r_mem_write   <= 1'b0;
        end else begin
            // done/err are single-cycle pulses
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_timer <= 8'h00;
                    if (w_req_any) begin
                        r_mem_addr    <= w_sel_addr;
                        r_mem_type    <= w_sel_type;
                        r_mem_write   <= w_sel_write;
                        r_mem_data_in <= w_sel_wdata;
                        r_mem_select  <= 1'b1;
                        r_owner       <= w_grant_b;
                        r_last_owner  <= w_grant_b;
                        r_state       <= ST_ACCESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_timer <= r_timer + 8'd1;
                    if (bus.mem_data_ready) begin
                        // Ready wins over a coincident timeout
                        r_mem_select <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_state      <= ST_RELEASE;
                        if (r_owner == OWNER_B) begin
                            r_b_done <= 1'b1;
                            if (!r_mem_write) begin
                                r_b_rdata <= bus.mem_data_out;
                            end else begin
                                r_b_rdata <= r_b_rdata;
                            end
                        end else begin
                            r_a_done <= 1'b1;
                            if (!r_mem_write) begin
                                r_a_rdata <= bus.mem_data_out;
                            end else begin
                                r_a_rdata <= r_a_rdata;
                            end
                        end
                    end else if (w_timeout) begin
                        r_mem_select <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_err        <= 1'b1;
                        r_state      <= ST_RELEASE;
                        if (r_owner == OWNER_B) begin
                            r_b_done  <= 1'b1;
                            r_b_rdata <= 8'h00;
                        end else begin
                            r_a_done  <= 1'b1;
                            r_a_rdata <= 8'h00;
                        end
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_RELEASE: begin
                    // One select-low cycle so the memory can re-arm
                    r_timer <= 8'h00;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_timer      <= 8'h00;
                    r_mem_select <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_done      = r_a_done;
    assign bus.a_rdata     = r_a_rdata;
    assign bus.b_done      = r_b_done;
    assign bus.b_rdata     = r_b_rdata;
    assign bus.err         = r_err;
    assign bus.mem_select  = r_mem_select;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.mem_type    = r_mem_type;
    assign bus.mem_write   = r_mem_write;

endmodule
